stack_ctrl: RTL and testbench
=============================

// Module: stack_ctrl
// PURPOSE
//   Initiator side of the 19-bit hardware stack interface. Accepts CALL/RET/PUSH/POP
//   requests from the CPU control unit and drives the stack's push/pop strobes.
//   Captures popped data and checks full/empty before every access. Returns one
//   response per request, raises PC redirects for RET, and keeps sticky error flags.
// PARAMETERS
//   DATA_W   19   width of request data, stack data, response data, PC target
// PORTS
//   clk            in   1       clock, all state on rising edge
//   reset          in   1       synchronous, active-high reset
//   req_valid      in   1       request present
//   req_ready      out  1       controller can accept a request (IDLE only)
//   req_op         in   2       00 PUSH, 01 POP, 10 CALL, 11 RET
//   req_data       in   DATA_W  value to push (PUSH) / return address (CALL)
//   rsp_valid      out  1       response present, held until rsp_ready
//   rsp_ready      in   1       consumer accepts response
//   rsp_op         out  2       op of the request being answered
//   rsp_data       out  DATA_W  popped value (POP/RET), else 0
//   rsp_err        out  1       request was refused (overflow or underflow)
//   pc_load        out  1       1-cycle pulse: load PC with pc_target (RET success)
//   pc_target      out  DATA_W  return address, valid while pc_load=1
//   stk_push       out  1       push strobe to stack
//   stk_pop        out  1       pop strobe to stack
//   stk_push_data  out  DATA_W  data to stack
//   stk_pop_data   in   DATA_W  stack top (combinational, valid when not empty)
//   stk_empty      in   1       stack empty
//   stk_full       in   1       stack full (15 entries)
//   err_ovf        out  1       sticky: PUSH/CALL refused on full
//   err_udf        out  1       sticky: POP/RET refused on empty
//   err_clr        in   1       clears err_ovf/err_udf
// BEHAVIOUR
//   - Reset: state IDLE; all outputs 0 except req_ready=1; latched op/data cleared.
//   - States: IDLE -> ISSUE -> RESP -> IDLE. No other states.
//   - IDLE: req_ready=1. On req_valid (cycle T) latch req_op, req_data; go ISSUE.
//   - ISSUE (T+1), always exactly one cycle, req_ready=0:
//       PUSH/CALL: if !stk_full assert stk_push=1, stk_push_data=latched data;
//         else no strobe, set rsp_err, set err_ovf.
//       POP/RET: if !stk_empty assert stk_pop=1 and capture stk_pop_data into rsp_data
//         in the same cycle; else no strobe, rsp_data=0, set rsp_err, set err_udf.
//       stk_push and stk_pop never both 1; both 0 outside ISSUE.
//   - RESP (from T+2): rsp_valid=1, rsp_op/rsp_data/rsp_err stable until rsp_ready=1;
//     on rsp_ready go IDLE (earliest next accept T+3).
//   - pc_load=1 for exactly the first RESP cycle when op=RET and rsp_err=0,
//     pc_target=popped value; pc_load never repeats during rsp_ready stall.
//   - full/empty sampled only in ISSUE; stack state never changes on a refused op.
//   - err flags: set on refusal in ISSUE; err_clr clears; set and clear in the same
//     cycle -> flag ends set.
//   - Reset mid-operation (ISSUE or RESP): return to IDLE next edge, strobes and
//     rsp_valid drop, pending response discarded, no pc_load issued.
//   - req_valid outside IDLE is ignored (not latched).
// TESTING
//   1 PUSH 0x12345 then POP -> T+1 stk_push, data 0x12345; POP rsp_data=0x12345, err=0.
//   2 15 PUSHes fill stack, 16th PUSH -> no stk_push, rsp_err=1, err_ovf=1 sticky.
//   3 POP/RET on empty stack -> no stk_pop, rsp_data=0, rsp_err=1, err_udf=1, no pc_load.
//   4 CALL 0x00400 then RET -> pc_load one cycle, pc_target=0x00400, stack empty after.
//   5 rsp_ready low 5 cycles in RESP -> rsp fields stable, pc_load single pulse, req_ready=0.
//   6 reset asserted in ISSUE of a PUSH -> state IDLE, rsp_valid never rises, req_ready=1.

Source files
------------

// File: rtl/stack_ctrl.sv
// Initiator-side controller for a 19-bit hardware stack.
// Accepts PUSH/POP/CALL/RET requests one at a time and drives the stack strobes.
// Full/empty are checked in the issue cycle, and each request gets exactly one response.
// A successful RET also produces a one-cycle PC redirect.
// Refused requests set sticky overflow/underflow flags.
module stack_ctrl #(
  parameter int unsigned DATA_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_op,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_target,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_push_data,
  input  logic [DATA_W-1:0] stk_pop_data,
  input  logic              stk_empty,
  input  logic              stk_full,
  output logic              err_ovf,
  output logic              err_udf,
  input  logic              err_clr
);

  localparam logic [1:0] OpRet = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] data_q;

  logic in_issue;
  logic push_like;
  logic refuse_ovf;
  logic refuse_udf;

  // Request classification and refusal decode; full/empty only matter while issuing
  always_comb begin
    in_issue   = (state == StIssue);
    push_like  = ~op_q[0];  // PUSH (00) and CALL (10) write the stack
    refuse_ovf = in_issue & push_like & stk_full;
    refuse_udf = in_issue & ~push_like & stk_empty;
  end

  // Stack strobes are live during the issue cycle so popped data is captured in that cycle
  always_comb begin
    stk_push      = in_issue & push_like & ~stk_full;
    stk_pop       = in_issue & ~push_like & ~stk_empty;
    stk_push_data = stk_push ? data_q : '0;
  end

  // Handshake outputs decode directly from the state register
  always_comb begin
    req_ready = (state == StIdle);
    rsp_valid = (state == StResp);
    rsp_op    = op_q;
    pc_target = rsp_data;
  end

  // Request FSM, response capture and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StIdle;
      op_q     <= '0;
      data_q   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      pc_load  <= 1'b0;
      err_ovf  <= 1'b0;
      err_udf  <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (req_valid) begin
            op_q     <= req_op;
            data_q   <= req_data;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            state    <= StIssue;
          end
        end
        StIssue: begin
          state <= StResp;
          if (push_like) begin
            rsp_data <= '0;
            rsp_err  <= stk_full;
          end else begin
            rsp_data <= stk_empty ? '0 : stk_pop_data;
            rsp_err  <= stk_empty;
            pc_load  <= (op_q == OpRet) & ~stk_empty;
          end
        end
        StResp: begin
          // Redirect covers only the first response cycle, even if the consumer stalls
          pc_load <= 1'b0;
          if (rsp_ready) begin
            state <= StIdle;
          end
        end
        default: begin
          state   <= StIdle;
          pc_load <= 1'b0;
        end
      endcase

      // A refusal in the same cycle as a clear leaves the flag set
      err_ovf <= refuse_ovf | (err_ovf & ~err_clr);
      err_udf <= refuse_udf | (err_udf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl.
// It includes a 15-entry stack that follows the strobes, directed vectors and hand sequences.
// It also runs a random phase, checking responses against a queue-based model of stack behaviour.
module tb_stack_ctrl;

  localparam int W = 19;
  localparam logic [1:0] OpPush = 2'b00;
  localparam logic [1:0] OpPop  = 2'b01;
  localparam logic [1:0] OpCall = 2'b10;
  localparam logic [1:0] OpRet  = 2'b11;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_op;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic         pc_load;
  logic [W-1:0] pc_target;
  logic         stk_push;
  logic         stk_pop;
  logic [W-1:0] stk_push_data;
  logic [W-1:0] stk_pop_data;
  logic         stk_empty;
  logic         stk_full;
  logic         err_ovf;
  logic         err_udf;
  logic         err_clr;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_ovf = 1'b0;
  logic exp_udf = 1'b0;
  logic [W-1:0] model_q[$];

  always #5 clk = ~clk;

  stack_ctrl #(.DATA_W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_op       (rsp_op),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .pc_load      (pc_load),
    .pc_target    (pc_target),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_push_data(stk_push_data),
    .stk_pop_data (stk_pop_data),
    .stk_empty    (stk_empty),
    .stk_full     (stk_full),
    .err_ovf      (err_ovf),
    .err_udf      (err_udf),
    .err_clr      (err_clr)
  );

  // 15-entry stack that follows the controller's strobes; it shares the reset
  logic [W-1:0] mem [15];
  logic [3:0]   cnt;

  always @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (stk_push && cnt < 4'd15) begin
      mem[cnt] <= stk_push_data;
      cnt      <= cnt + 4'd1;
    end else if (stk_pop && cnt > 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign stk_empty    = (cnt == 4'd0);
  assign stk_full     = (cnt == 4'd15);
  assign stk_pop_data = (cnt == 4'd0) ? '0 : mem[cnt - 4'd1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: strobes exclusive, never push into full or pop from empty
  always @(negedge clk) begin
    if (!reset) begin
      check("strobe_excl", 32'(stk_push & stk_pop), 32'd0);
      check("push_on_full", 32'(stk_push & stk_full), 32'd0);
      check("pop_on_empty", 32'(stk_pop & stk_empty), 32'd0);
    end
  end

  // One complete request/response transaction with cycle-accurate checks
  task automatic do_req(input logic [1:0] op, input logic [W-1:0] data, input int stall,
                        input logic clr_issue, input logic exp_err, input logic [W-1:0] exp_data);
    logic push_like;
    logic exp_pc;
    push_like = ~op[0];
    exp_pc    = (op == OpRet) && !exp_err;
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    @(negedge clk);
    // Issue cycle
    check("issue_req_ready", 32'(req_ready), 32'd0);
    check("issue_rsp_valid", 32'(rsp_valid), 32'd0);
    check("issue_push", 32'(stk_push), 32'(push_like && !exp_err));
    check("issue_pop", 32'(stk_pop), 32'(!push_like && !exp_err));
    if (push_like && !exp_err) check("issue_push_data", 32'(stk_push_data), 32'(data));
    // Requests presented while busy must be ignored
    req_valid = 1'($urandom_range(0, 1));
    req_op    = 2'($urandom_range(0, 3));
    req_data  = W'($urandom);
    err_clr   = clr_issue;
    @(negedge clk);
    err_clr = 1'b0;
    if (clr_issue) begin
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end
    if (exp_err) begin
      if (push_like) exp_ovf = 1'b1;
      else exp_udf = 1'b1;
    end
    // First response cycle
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_op", 32'(rsp_op), 32'(op));
    check("rsp_data", 32'(rsp_data), 32'(exp_data));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("pc_load", 32'(pc_load), 32'(exp_pc));
    if (exp_pc) check("pc_target", 32'(pc_target), 32'(exp_data));
    check("err_ovf", 32'(err_ovf), 32'(exp_ovf));
    check("err_udf", 32'(err_udf), 32'(exp_udf));
    check("resp_strobes", 32'(stk_push | stk_pop), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_data", 32'(rsp_data), 32'(exp_data));
      check("stall_rsp_err", 32'(rsp_err), 32'(exp_err));
      check("stall_rsp_op", 32'(rsp_op), 32'(op));
      check("stall_pc_load", 32'(pc_load), 32'd0);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("done_rsp_valid", 32'(rsp_valid), 32'd0);
    check("done_req_ready", 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] data;
    int           stall;
    logic         exp_err;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [1:0]   op;
    logic [W-1:0] data;
    logic         err;
    logic [W-1:0] edata;

    vecs[0] = '{OpPush, 19'h12345, 0, 1'b0, 19'h0};
    vecs[1] = '{OpPop,  19'h0,     1, 1'b0, 19'h12345};
    vecs[2] = '{OpPop,  19'h0,     0, 1'b1, 19'h0};
    vecs[3] = '{OpRet,  19'h0,     2, 1'b1, 19'h0};
    vecs[4] = '{OpCall, 19'h00400, 0, 1'b0, 19'h0};
    vecs[5] = '{OpRet,  19'h0,     5, 1'b0, 19'h00400};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_data  = '0;
    rsp_ready = 1'b0;
    err_clr   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_op", 32'(rsp_op), 32'd0);
    check("rst_pc_load", 32'(pc_load), 32'd0);
    check("rst_strobes", 32'({stk_push, stk_pop}), 32'd0);
    check("rst_err_flags", 32'({err_ovf, err_udf}), 32'd0);
    reset = 1'b0;

    // Directed vectors: push/pop round trip, empty refusals, CALL/RET with stalled response
    for (int i = 0; i < 6; i++) begin
      do_req(vecs[i].op, vecs[i].data, vecs[i].stall, 1'b0, vecs[i].exp_err, vecs[i].exp_data);
    end
    @(negedge clk);
    check("stack_empty_after_ret", 32'(cnt), 32'd0);

    // Fill to 15, the 16th push is refused; clearing in that same cycle keeps ovf set
    for (int i = 0; i < 16; i++) begin
      do_req(OpPush, W'(32'h100 + i), i % 2, (i == 15), (i == 15), '0);
    end
    check("full_count", 32'(cnt), 32'd15);
    check("ovf_sticky", 32'(err_ovf), 32'd1);
    check("udf_cleared", 32'(err_udf), 32'd0);
    do_req(OpCall, 19'h7ABCD, 1, 1'b0, 1'b1, '0);

    // Clear from idle
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    check("clr_ovf", 32'(err_ovf), 32'd0);
    check("clr_udf", 32'(err_udf), 32'd0);

    // Drain in LIFO order
    for (int i = 14; i >= 0; i--) begin
      do_req(OpPop, '0, 0, 1'b0, 1'b0, W'(32'h100 + i));
    end

    // Reset while issuing a push: no response, back to idle
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OpPush;
    req_data  = 19'h5A5A5;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid_push_issue", 32'(stk_push), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_req_ready", 32'(req_ready), 32'd1);
    check("rstmid_strobe", 32'(stk_push), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
      check("rstmid_no_pc", 32'(pc_load), 32'd0);
      @(negedge clk);
    end
    check("rstmid_idle", 32'(req_ready), 32'd1);
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    model_q.delete();

    // Random operations against a LIFO model with a 15-entry bound
    for (int n = 0; n < 300; n++) begin
      op    = 2'($urandom_range(0, 3));
      data  = W'($urandom);
      edata = '0;
      if (!op[0]) begin
        err = (model_q.size() == 15);
        if (!err) model_q.push_back(data);
      end else begin
        err = (model_q.size() == 0);
        if (!err) edata = model_q.pop_back();
      end
      do_req(op, data, $urandom_range(0, 3), ($urandom_range(0, 9) == 0), err, edata);
    end
    @(negedge clk);
    check("final_depth", 32'(cnt), 32'(model_q.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
